// File: rtl/mul_seq_engine.sv
// Sequential radix-2 shift-add multiplier that fetches two WIDTH-bit operands from
// byte-wide data memory and writes the 2*WIDTH-bit product back little-endian.
module mul_seq_engine #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              signed_mode,
    input  logic [7:0]        mem_rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    // Handshake: a request is a high-to-low transition of start seen in S_IDLE;
    // done stays high in S_DONE until start is observed high again.
    localparam int NB = WIDTH / 8;
    localparam int CW = 6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MUL   = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_n;

    logic              start_q;
    logic              mode_q;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH:0]    hi;
    logic [WIDTH+1:0]  hi_x;
    logic [WIDTH+1:0]  a_x;
    logic [WIDTH+1:0]  sum;
    logic [2*WIDTH-1:0] prod;
    logic [7:0]        wr_byte;
    logic              request;
    logic              last_bit;

    assign request  = start_q & ~start;
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign hi_x     = {hi[WIDTH], hi};
    assign a_x      = {{2{mode_q & a_reg[WIDTH-1]}}, a_reg};
    assign prod     = {hi[WIDTH-1:0], lo};

    // The multiplier MSB carries negative weight in signed mode, so it subtracts A.
    always_comb begin
        sum = hi_x;
        if (lo[0]) begin
            if (mode_q && last_bit) sum = hi_x - a_x;
            else                    sum = hi_x + a_x;
        end
    end

    always_comb begin
        wr_byte = 8'h00;
        for (int k = 0; k < 2*NB; k++) begin
            if (cnt == CW'(k)) wr_byte = prod[8*k +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        mem_addr    = ADDR_W'(BASE);
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'h00;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (request) state_n = S_LOAD;
            end
            S_LOAD: begin
                busy     = 1'b1;
                mem_addr = ADDR_W'(BASE) + ADDR_W'(cnt);
                if (cnt == CW'(2*NB - 1)) state_n = S_MUL;
            end
            S_MUL: begin
                busy = 1'b1;
                if (last_bit) state_n = S_STORE;
            end
            S_STORE: begin
                busy        = 1'b1;
                mem_addr    = ADDR_W'(BASE + 2*NB) + ADDR_W'(cnt);
                mem_wr_en   = 1'b1;
                mem_wr_data = wr_byte;
                if (cnt == CW'(2*NB - 1)) state_n = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= 1'b1;
            mode_q  <= 1'b0;
            cnt     <= '0;
            a_reg   <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            start_q <= start;
            if (state_n != state || state == S_IDLE || state == S_DONE) cnt <= '0;
            else                                                      cnt <= cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (request) begin
                        mode_q <= signed_mode;
                        hi     <= '0;
                    end
                end
                S_LOAD: begin
                    for (int k = 0; k < NB; k++) begin
                        if (cnt == CW'(k))      a_reg[8*k +: 8] <= mem_rd_data;
                        if (cnt == CW'(NB + k)) lo[8*k +: 8]    <= mem_rd_data;
                    end
                end
                S_MUL: begin
                    hi <= sum[WIDTH+1:1];
                    lo <= {sum[0], lo[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mul_seq_engine.md
Name: mul_seq_engine

Overview:
- Parametrised hardware successor to the 8x8 signed product program.
- Multiplies two WIDTH-bit operands held in byte-wide data memory and writes the 2*WIDTH-bit product back little-endian.
- Uses a radix-2 shift-add datapath with a start/done handshake.
- Sits beside the core on the data-memory port and adds a runtime signed/unsigned mode.

Parameters:
- WIDTH, 8: operand width in bits; must be a multiple of 8, range 8..32. NB = WIDTH/8 bytes per operand.
- ADDR_W, 8: data-memory byte address width.
- BASE, 0: byte address of operand A.
  - Operand B is at BASE+NB.
  - Product is at BASE+2*NB .. BASE+4*NB-1.

Ports:
- clk          in   1         system clock, all state on rising edge
- reset        in   1         asynchronous, active-high; clears all state
- start        in   1         a falling edge requests one multiply
- signed_mode  in   1         1 = two's-complement operands, 0 = unsigned; sampled on the start falling edge
- mem_rd_data  in   8         byte read from mem_addr, combinational (same cycle)
- mem_addr     out  ADDR_W    byte address
- mem_wr_en    out  1         write strobe, one byte per cycle
- mem_wr_data  out  8         byte to write
- busy         out  1         high from the accepted request until done rises
- done         out  1         high when the product is in memory; held until start returns high

Behaviour:
- Reset values (asynchronous): state=IDLE, done=0, busy=0, mem_wr_en=0, mem_addr=BASE, mem_wr_data=0, start_q=1.
- Edge detect:
  - start_q registers start every cycle.
  - A request is start_q=1 and start=0, evaluated in IDLE only.
  - Falling edges in any other state are ignored.
  - Because start_q resets to 1, start already low when reset releases counts as a request.
- States: IDLE -> LOAD -> MUL -> STORE -> DONE.
  - IDLE:
    - mem_addr=BASE, busy=0.
    - On a request: latch signed_mode, go to LOAD, busy=1.
  - LOAD, 2*NB cycles, byte counter i=0..2*NB-1:
    - mem_addr=BASE+i.
    - Bytes 0..NB-1 fill A little-endian; bytes NB..2NB-1 fill B little-endian.
  - MUL, WIDTH cycles:
    - Accumulator is 2*WIDTH+1 bits. Process one multiplier bit of B per cycle, LSB first.
    - Add A when the bit is 1, then shift.
    - Signed mode, bit WIDTH-1 of B: subtract A instead of adding (Baugh/Booth-equivalent correction).
    - Signed mode extends A by sign; unsigned mode extends A by zero.
    - The result is exact for all inputs. Signed results are in -2^(2W-2)..2^(2W-2); unsigned results are in 0..(2^W-1)^2.
  - STORE, 2*NB cycles, j=0..2*NB-1:
    - mem_addr=BASE+2*NB+j, mem_wr_en=1, mem_wr_data=product byte j.
    - Byte j=0 is the least significant (little-endian).
  - DONE:
    - done=1, busy=0, mem_wr_en=0.
    - Stay until start=1, then done=0 next edge and go to IDLE.
    - A new multiply needs a fresh falling edge.
- Latency: with E0 as the rising edge that samples the request, done is high after edge E0+4*NB+WIDTH. For WIDTH=8 that is 12 cycles; for WIDTH=16, 24 cycles.
- mem_wr_en is high only in STORE; no memory write ever occurs outside STORE.
- Operand memory is read only in LOAD. Operands may be changed by the host after LOAD without affecting the result.
- Reset mid-operation:
  - Immediate return to IDLE with done=0 and busy=0.
  - Product bytes already written stay in memory; remaining bytes are not written.
  - No request is pending after reset releases unless start is low.
- signed_mode changes after acceptance have no effect on the current operation.

Test Plan:
- WIDTH=8, signed, mem[0]=2, mem[1]=-4, pulse start low -> mem[2]=0xF8, mem[3]=0xFF; done at E0+12; busy low on that same edge.
- WIDTH=8, signed, -128 * -128 -> {mem[3],mem[2]}=0x4000. Then 127 * -128 -> 0xC080.
- WIDTH=8, unsigned, 0xFF * 0xFF -> 0xFE01. Same operands in signed mode -> 0x0001.
- WIDTH=8, toggle start high/low twice during MUL -> ignored, single result at E0+12. Hold start low in DONE -> done stays 1, no second run. Raise start -> done=0 next edge.
- WIDTH=8, assert reset at cycle E0+9 (mid-MUL):
  - done=0, busy=0, mem_wr_en=0 immediately.
  - mem[2..3] unchanged.
  - Release reset, start low -> full correct result 12 cycles later.
- WIDTH=16, BASE=0, signed, A=-300, B=1000 -> mem[4..7]=0x20,0x6C,0xFB,0xFF (-300000); done at E0+24.
